// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped interval timer.
package bus_timer_pkg;

    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_LOAD   = 32'h04;
    localparam logic [31:0] OFF_COUNT  = 32'h08;
    localparam logic [31:0] OFF_STATUS = 32'h0C;
    localparam logic [31:0] OFF_PRESC  = 32'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IE     = 2;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } busState_t;

    function automatic logic [31:0] mergeHalf(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic        half,
        input logic        upper
    );
        if (!half)
            return data;
        return upper ? {data[15:0], old[15:0]} : {old[31:16], data[15:0]};
    endfunction

endpackage

// File: rtl/bus_timer_tick.sv
// Prescaler: one tick every presc+1 enabled cycles.
module tick_gen
    import bus_timer_pkg::*;
#(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic               restart,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = en && (cnt == '0);

    // While disabled the divider sits preloaded so the first tick
    // lands exactly presc+1 cycles after enabling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!en || restart || tick)
            cnt <= presc;
        else
            cnt <= cnt - PRESC_W'(1);
    end

endmodule

// File: rtl/bus_timer.sv
// Bus responder with MemOK handshake, timer registers and interrupt.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int PRESC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ChipSelect,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              SaveHalf,
    input  logic              LoadHalf,
    input  logic [31:0]       WriteData,
    output logic [31:0]       MemReadData,
    output logic              MemOK,
    input  logic              InteAccept,
    output logic              TimerInte
);

    busState_t          state;
    logic [2:0]         ctrl, ctrlNext;
    logic [31:0]        load, loadNext;
    logic [31:0]        count, countNext;
    logic               exp, expNext;
    logic [PRESC_W-1:0] presc, prescNext;

    logic [ADDR_W-1:0]  offset;
    logic [31:0]        rdWord, rdData, wrVal;
    logic               request, commit, tick, tickEff, expire;
    logic               restart, expClear;

    assign offset  = Addr & ~ADDR_W'(3);
    assign request = (state == IDLE) && ChipSelect && (MemRead || MemWrite);
    assign commit  = request && MemWrite;

    always_comb begin
        rdWord = '0;
        case (offset)
            ADDR_W'(OFF_CTRL):   rdWord = {29'd0, ctrl};
            ADDR_W'(OFF_LOAD):   rdWord = load;
            ADDR_W'(OFF_COUNT):  rdWord = count;
            ADDR_W'(OFF_STATUS): rdWord = {31'd0, exp};
            ADDR_W'(OFF_PRESC):  rdWord = 32'(presc);
            default:             rdWord = '0;
        endcase
    end

    assign rdData = LoadHalf
        ? {16'h0, Addr[1] ? rdWord[31:16] : rdWord[15:0]}
        : rdWord;

    assign wrVal = mergeHalf(rdWord, WriteData, SaveHalf, Addr[1]);

    // An upper-half STATUS write never touches EXP.
    assign expClear = InteAccept
        || (commit && offset == ADDR_W'(OFF_STATUS)
            && !(SaveHalf && Addr[1]) && WriteData[0]);

    assign tickEff = tick
        && !(commit && offset == ADDR_W'(OFF_CTRL) && !wrVal[CTRL_EN]);
    assign expire  = tickEff && (count == '0);

    always_comb begin
        ctrlNext  = ctrl;
        loadNext  = load;
        countNext = count;
        prescNext = presc;
        expNext   = exp;
        if (expClear)
            expNext = 1'b0;
        if (tickEff) begin
            if (count != '0)
                countNext = count - 32'd1;
            else if (ctrl[CTRL_RELOAD])
                countNext = load;
            else
                ctrlNext[CTRL_EN] = 1'b0;
        end
        if (expire)
            expNext = 1'b1;
        if (commit) begin
            case (offset)
                ADDR_W'(OFF_CTRL):  ctrlNext  = wrVal[2:0];
                ADDR_W'(OFF_LOAD):  loadNext  = wrVal;
                ADDR_W'(OFF_COUNT): countNext = wrVal;
                ADDR_W'(OFF_PRESC): prescNext = wrVal[PRESC_W-1:0];
                default: ;
            endcase
        end
    end

    assign restart = !ctrl[CTRL_EN] && ctrlNext[CTRL_EN];

    tick_gen #(.PRESC_W(PRESC_W)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .en      (ctrl[CTRL_EN]),
        .presc   (presc),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl      <= '0;
            load      <= '0;
            count     <= '0;
            exp       <= 1'b0;
            presc     <= '0;
            TimerInte <= 1'b0;
        end else begin
            ctrl      <= ctrlNext;
            load      <= loadNext;
            count     <= countNext;
            exp       <= expNext;
            presc     <= prescNext;
            TimerInte <= expNext && ctrlNext[CTRL_IE];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            MemOK       <= 1'b0;
            MemReadData <= '0;
        end else begin
            unique case (state)
                IDLE: if (request) begin
                    state <= ACK;
                    MemOK <= 1'b1;
                    if (MemRead)
                        MemReadData <= rdData;
                end
                ACK: if (!ChipSelect || !(MemRead || MemWrite)) begin
                    state <= IDLE;
                    MemOK <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_timer.md
# bus_timer

Memory-mapped programmable interval timer that acts as a responder on the board's CPU memory bus. It answers the bus's ChipSelect/MemRead/MemWrite request with a MemOK four-phase handshake and supports word and halfword (SaveHalf/LoadHalf) accesses. It also counts down a prescaled reload value and raises a level interrupt that is cleared by the CPU's interrupt-accept pulse. It sits beside the keyboard and disk controllers on the board, in its own address window decoded by the board.

## Interface
- ADDR_W, 9, byte-address bits taken from MemAddr
- PRESC_W, 16, prescaler width
- clk  in  1  sole clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- ChipSelect  in  1  window decode from the board
- Addr  in  ADDR_W  byte address; bits [1:0] ignored except bit1 for halfword accesses
- MemRead  in  1  read request, held until MemOK is seen
- MemWrite  in  1  write request, held until MemOK is seen
- SaveHalf  in  1  halfword write; Addr[1] selects the half
- LoadHalf  in  1  halfword read; Addr[1] selects the half
- WriteData  in  32  write data; a halfword write uses [15:0]
- MemReadData  out  32  registered read data; reset value 0
- MemOK  out  1  access-complete flag; reset value 0
- InteAccept  in  1  CPU interrupt acknowledge
- TimerInte  out  1  interrupt level; reset value 0

## Operation
- Registers, by word offset:
  - 0x00 CTRL: [0] EN, [1] RELOAD, [2] IE.
  - 0x04 LOAD: 32-bit reload value.
  - 0x08 COUNT: live counter; R/W.
  - 0x0C STATUS: [0] EXP; writing 1 clears it, writing 0 has no effect.
  - 0x10 PRESC: PRESC_W bits.
  - Any other offset reads 0 and ignores writes.
- Reset values: all registers 0, the FSM in IDLE, MemOK 0, MemReadData 0.
- Halfword write: Addr[1]=0 writes [15:0] and Addr[1]=1 writes [31:16]. The other half is unchanged.
- Halfword read: returns {16'h0, selected half}.
- Handshake FSM, state IDLE:
  - If ChipSelect & (MemRead|MemWrite), perform the access at that edge: latch the read data or commit the write. Set MemOK=1 and go to ACK.
  - If MemRead and MemWrite are both high, the write is committed and the read data is also returned.
- Handshake FSM, state ACK:
  - Hold MemOK=1 and MemReadData while MemRead|MemWrite stays high.
  - When both are low, or ChipSelect is low, clear MemOK and go to IDLE.
  - A single request is never performed twice.
- Tick generator:
  - Runs only while EN=1.
  - Emits one tick every PRESC+1 cycles. PRESC=0 gives a tick every cycle.
  - The divider is cleared when EN goes 0→1, including when EN is set by a bus write.
- Counter, on each tick:
  - If COUNT≠0, COUNT decrements.
  - If COUNT==0, EXP is set. With RELOAD=1, COUNT loads LOAD. With RELOAD=0, COUNT stays 0 and EN is cleared.
- TimerInte = EXP & IE. InteAccept clears EXP.
- Simultaneous events:
  - Expiry tick and InteAccept or an EXP-clear write in the same cycle: EXP stays set.
  - Bus write to COUNT and a tick in the same cycle: the written value wins, with no decrement.
  - Bus write to CTRL clearing EN and a tick in the same cycle: the tick is discarded.
- All arithmetic is unsigned 32-bit. COUNT never wraps below 0.

## Timing
- Request visible before edge N → MemOK=1 and valid MemReadData after edge N, which is 1-cycle latency.
- The board samples MemOK and drops the request at edge N+1. MemOK falls after edge N+2.
- Back-to-back requests: a new request is accepted in IDLE no earlier than edge N+3.
- Writes take effect at edge N. A read at edge N+1 sees the new value.
- TimerInte is registered. It rises the cycle after the expiring tick and falls the cycle after InteAccept.
- Asynchronous reset mid-transaction: MemOK drops immediately, the FSM goes to IDLE, and the pending write is lost if it was not yet committed.

## Structure
- Package bus_timer_pkg holds:
  - register offsets (CTRL, LOAD, COUNT, STATUS, PRESC)
  - CTRL bit indices (EN, RELOAD, IE)
  - FSM state encoding (IDLE, ACK)
- Sub-module tick_gen: prescaler down-counter with inputs en, presc, restart and output tick.
- The top level holds the handshake FSM, the register file, and the counter/interrupt logic.

## Test plan
- Bus handshake: word write 0x1234_5678 to LOAD, then read LOAD.
  - Expect MemOK high 1 cycle after the request, held until the request drops, then low the cycle after.
  - The read returns 0x1234_5678. The write commits exactly once.
- Halfword access:
  - SaveHalf 0xBEEF at offset 0x06 over LOAD=0 → LOAD reads 0xBEEF_0000.
  - LoadHalf at 0x04 → 0x0000_0000. LoadHalf at 0x06 → 0x0000_BEEF.
- One-shot:
  - Setup: PRESC=1, COUNT=3, CTRL=EN|IE.
  - EXP and TimerInte are set after 8 cycles (4 ticks × 2). COUNT=0 and EN=0.
  - InteAccept → TimerInte low the next cycle.
- Auto-reload:
  - Setup: LOAD=2, PRESC=0, CTRL=EN|RELOAD, COUNT=0.
  - COUNT sequence is 2,1,0,2,1,0 and EXP sets every third cycle.
- Collision: an expiry tick and InteAccept in the same cycle → EXP remains 1.
- Reset and boundaries:
  - rst asserted while MemOK=1 → MemOK, TimerInte, MemReadData and all registers read 0.
  - A read of unmapped offset 0x1FC returns 0.
